// File: rtl/digit_string_renderer.sv
// Renders an N-digit decimal number onto the VGA raster from a shared 1-bit digit-strip ROM.
// A double-dabble FSM converts the binary value once per frame; a 3-stage pipeline produces colour.
module digit_string_renderer #(
    parameter int         NUM_DIGITS  = 4,
    parameter int         VALUE_W     = 14,
    parameter int         X0          = 0,
    parameter int         Y0          = 0,
    parameter int         SCALE_SHIFT = 0,
    parameter int         GLYPH_W     = 45,
    parameter int         GLYPH_H     = 36,
    parameter int         ROM_PITCH   = 450,
    parameter int         LZ_BLANK    = 1,
    parameter logic [3:0] FG_R        = 4'hF,
    parameter logic [3:0] FG_G        = 4'hF,
    parameter logic [3:0] FG_B        = 4'h0
) (
    input  logic               vga_clk,
    input  logic               Reset,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic [VALUE_W-1:0] value,
    input  logic               frame_start,
    output logic [13:0]        rom_addr,
    input  logic               rom_q,
    output logic               busy,
    output logic               pixel_on,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    function automatic logic [63:0] max_display();
        logic [63:0] m;
        m = 64'd1;
        for (int i = 0; i < NUM_DIGITS; i++) m = m * 64'd10;
        return m - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_display();
    localparam logic [31:0] X_LO = 32'(X0);
    localparam logic [31:0] X_HI = 32'(X0 + ((NUM_DIGITS * GLYPH_W) << SCALE_SHIFT));
    localparam logic [31:0] Y_LO = 32'(Y0);
    localparam logic [31:0] Y_HI = 32'(Y0 + (GLYPH_H << SCALE_SHIFT));

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]         state;
    logic               start_req;
    logic [VALUE_W-1:0] bin;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   adjusted;
    logic [BCD_W-1:0]   disp;
    logic [CNT_W-1:0]   cnt;
    logic [VALUE_W-1:0] clamped;

    assign clamped = (64'(value) > MAX_VAL) ? VALUE_W'(MAX_VAL) : value;
    // Start requests are registered, so a pulse that lands while busy is simply dropped.
    assign busy    = start_req || (state != IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign adjusted[4*gi +: 4] = (scratch[4*gi +: 4] >= 4'd5) ?
                                         scratch[4*gi +: 4] + 4'd3 : scratch[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            start_req <= 1'b0;
            bin       <= '0;
            scratch   <= '0;
            disp      <= '0;
            cnt       <= '0;
        end else begin
            start_req <= frame_start && (state == IDLE) && !start_req;
            case (state)
                IDLE: begin
                    if (start_req) begin
                        bin     <= clamped;
                        scratch <= '0;
                        cnt     <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, bin} <= {adjusted, bin} << 1;
                    cnt            <= cnt + 1'b1;
                    if (cnt == CNT_W'(VALUE_W - 1)) state <= COMMIT;
                end
                COMMIT: begin
                    disp  <= scratch;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slot s is a leading zero when every nibble from the most significant down to s is zero.
    logic [NUM_DIGITS-1:0] blanked;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            assign blanked[gi] = (LZ_BLANK != 0) && (gi != NUM_DIGITS - 1) &&
                                 (disp[BCD_W-1 -: 4*(gi+1)] == '0);
        end
    endgenerate

    logic        in_box;
    logic [31:0] lx, ly, slot, col;
    logic [3:0]  digit;
    logic        slot_blank;
    logic [13:0] addr_next;

    always_comb begin
        in_box = (32'(DrawX) >= X_LO) && (32'(DrawX) < X_HI) &&
                 (32'(DrawY) >= Y_LO) && (32'(DrawY) < Y_HI);
        lx     = (32'(DrawX) - X_LO) >> SCALE_SHIFT;
        ly     = (32'(DrawY) - Y_LO) >> SCALE_SHIFT;
        slot   = lx / 32'(GLYPH_W);
        col    = lx - slot * 32'(GLYPH_W);
        digit      = 4'd0;
        slot_blank = 1'b0;
        for (int s = 0; s < NUM_DIGITS; s++) begin
            if (slot == 32'(s)) begin
                digit      = disp[4*(NUM_DIGITS-1-s) +: 4];
                slot_blank = blanked[s];
            end
        end
        addr_next = 14'(col + 32'(GLYPH_W) * 32'(digit) + ly * 32'(ROM_PITCH));
    end

    logic vis1, vis2, blank1, blank2, pix_next;
    assign pix_next = vis2 && rom_q && blank2;

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            rom_addr <= '0;
            vis1     <= 1'b0;
            blank1   <= 1'b0;
            vis2     <= 1'b0;
            blank2   <= 1'b0;
            pixel_on <= 1'b0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else begin
            rom_addr <= in_box ? addr_next : 14'd0;
            vis1     <= in_box && !slot_blank;
            blank1   <= blank;
            vis2     <= vis1;
            blank2   <= blank1;
            pixel_on <= pix_next;
            red      <= pix_next ? FG_R : 4'h0;
            green    <= pix_next ? FG_G : 4'h0;
            blue     <= pix_next ? FG_B : 4'h0;
        end
    end

endmodule

// File: doc/digit_string_renderer.md
Name: digit_string_renderer

Overview:
- Parametrised successor to the single-digit sprite renderer.
- Renders an N-digit decimal number (sun count, score, wave number) from a binary value onto the VGA raster, using the shared 450x36 1-bit digit-strip ROM (ten 45-px glyphs side by side).
- Binary-to-BCD conversion is an iterative double-dabble FSM, latched once per frame on frame_start to avoid tearing.
- Adds screen position, integer scaling, saturation, leading-zero blanking and a 3-cycle pixel pipeline.

Parameters:
- NUM_DIGITS, 4, number of digit slots; slot 0 is leftmost (most significant).
- VALUE_W, 14, width of the binary input value.
- X0, 0, left pixel column of the string.
- Y0, 0, top pixel row of the string.
- SCALE_SHIFT, 0, glyph magnification 2^SCALE_SHIFT (0..2).
- GLYPH_W, 45, glyph width in ROM pixels.
- GLYPH_H, 36, glyph height in ROM pixels.
- ROM_PITCH, 450, ROM row stride in pixels.
- LZ_BLANK, 1, 1 = blank leading zeros.
- FG_R / FG_G / FG_B, 4'hF / 4'hF / 4'h0, foreground colour for ROM bit 1.

Ports:
- vga_clk  in  1  pixel clock; all state is on posedge.
- Reset  in  1  asynchronous, active-high.
- DrawX  in  10  current raster column.
- DrawY  in  10  current raster row.
- blank  in  1  1 = active video.
- value  in  VALUE_W  unsigned number to display.
- frame_start  in  1  one-cycle pulse; starts a conversion.
- rom_addr  out  14  registered address to the digit ROM.
- rom_q  in  1  ROM data, valid one posedge after rom_addr.
- busy  out  1  conversion in progress.
- pixel_on  out  1  registered; 1 = this pixel is glyph foreground.
- red / green / blue  out  4 each  registered colour.

Behaviour:
- Reset (async, active-high):
  - FSM to IDLE; display BCD register = 0; all pipeline registers = 0.
  - Outputs rom_addr, busy, pixel_on, red, green and blue all 0.
- FSM states:
  - IDLE: on frame_start, load clamp(value), set BCD scratch = 0, go to SHIFT.
    - clamp(value) = min(value, 10^NUM_DIGITS - 1).
  - SHIFT: exactly VALUE_W cycles. Each cycle, add 3 to every scratch nibble >= 5, then shift {scratch, bin} left by 1.
  - COMMIT: one cycle; copy scratch into the display register; go to IDLE.
- busy is 1 in SHIFT and COMMIT.
- The display register updates VALUE_W+2 cycles after the frame_start edge; it never changes outside COMMIT.
- frame_start while busy is ignored; value may change freely during conversion.
- Render geometry:
  - lx = (DrawX - X0) >> SCALE_SHIFT; ly = (DrawY - Y0) >> SCALE_SHIFT.
  - in_box = DrawX >= X0, DrawX < X0 + NUM_DIGITS*GLYPH_W << SCALE_SHIFT, DrawY >= Y0, DrawY < Y0 + GLYPH_H << SCALE_SHIFT.
  - slot = lx / GLYPH_W; col = lx - slot*GLYPH_W; d = display digit of slot.
- Leading-zero blanking (LZ_BLANK = 1): slot s is blanked if it and all slots left of it are 0 and s != NUM_DIGITS-1. A value of 0 therefore shows a single "0".
- Pipeline (edge k samples DrawX/DrawY):
  - Edge k: rom_addr <= col + GLYPH_W*d + ly*ROM_PITCH (0 when !in_box); vis <= in_box && !blanked.
  - Edge k+1: ROM presents rom_q; vis and blank delayed in step.
  - Edge k+2: pixel_on <= vis && rom_q && blank. Colour <= FG when pixel_on is set, else 0.
  - Total latency from DrawX/DrawY to colour outputs: 3 posedges; the caller offsets accordingly.
- Arithmetic: compute address terms at full width, then truncate to 14 bits. Parameters are constrained so the maximum address is < 16384.
- Reset mid-conversion: abort, display register returns to 0, pipeline flushes to 0.

Test Plan:
- Reset, then idle rendering -> all outputs 0, busy 0; display register reads 0.
- value=1234, frame_start pulse -> busy=1 for exactly 16 cycles; display digits 1,2,3,4 at cycle 16.
- value=12345 (NUM_DIGITS=4) -> display 9,9,9,9.
- value=7, LZ_BLANK=1 -> slots 0..2 have pixel_on=0 across their full box; slot 3 renders glyph 7.
- value=1234, X0=Y0=0, DrawX=48, DrawY=2 -> rom_addr=993 one edge later (col 3, digit 2, row 2). With rom_q=1 and blank=1: pixel_on=1 and rgb=F,F,0 three edges after sampling. DrawX=180 -> pixel_on=0.
- Second frame_start during busy -> ignored, single update. Reset asserted mid-SHIFT -> busy=0 immediately, display 0. SCALE_SHIFT=1, DrawX=2,3 -> same rom_addr.
